uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx.sv | 155 +++++++++++++++
 tb/tb_uart_tx.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and data widths.
// Kept separate so a future receiver can reuse the same encodings.
package uart_tx_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned DEFAULT_FIFO_DEPTH   = 4;
    localparam int unsigned DATA_W               = 8;
    localparam int unsigned BIT_IDX_W            = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter: power-of-two depth, wrapping pointers,
// occupancy count one bit wider than the pointers so full and empty are distinct.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_pop,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO; frames are sent back to back
// while bytes are queued, and a write into a full FIFO is dropped and flagged.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              txd,
    output logic              busy,
    output logic              tx_overflow
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_W - 1);

    tx_state_e            r_state;
    tx_state_e            w_state_next;
    logic [BAUD_W-1:0]    r_baud;
    logic [BAUD_W-1:0]    w_baud_next;
    logic [BIT_IDX_W-1:0] r_bit_idx;
    logic [BIT_IDX_W-1:0] w_bit_idx_next;
    logic [DATA_W-1:0]    r_shift;
    logic [DATA_W-1:0]    w_fifo_data;
    logic                 r_txd;
    logic                 w_txd_next;
    logic                 r_busy;
    logic                 w_busy_next;
    logic                 r_overflow;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_baud_done;
    logic [CNT_W-1:0]     w_count;
    logic [CNT_W-1:0]     w_count_next;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clka),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (tx_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Ready depends only on the registered count, never on tx_start.
    assign tx_ready    = !w_full;
    assign w_push      = tx_start && !w_full;
    assign w_baud_done = (r_baud == BAUD_LAST);

    always_comb begin
        w_count_next = w_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = w_count + CNT_W'(1);
            2'b01:   w_count_next = w_count - CNT_W'(1);
            default: w_count_next = w_count;
        endcase
    end

    assign w_busy_next = (w_state_next != S_IDLE) || (w_count_next != '0);

    // Next-state logic; txd is computed from the next state so the line changes on the transition edge.
    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud + BAUD_W'(1);
        w_bit_idx_next = r_bit_idx;
        w_pop          = 1'b0;
        w_txd_next     = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_baud_next    = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_bit_idx == LAST_BIT) begin
                        w_bit_idx_next = '0;
                        w_state_next   = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + BIT_IDX_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_baud_next  = '0;
                w_state_next = S_IDLE;
            end
        endcase
        case (w_state_next)
            S_START: w_txd_next = 1'b0;
            S_DATA:  w_txd_next = r_shift[w_bit_idx_next];
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_txd     <= w_txd_next;
            r_busy    <= w_busy_next;
            if (w_pop) r_shift <= w_fifo_data;
            if (tx_start && w_full) r_overflow <= 1'b1;
        end
    end

    assign txd         = r_txd;
    assign busy        = r_busy;
    assign tx_overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model plus an
// independent serial receiver that decodes the txd line.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clka;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic       tx_overflow;

    int total = 0;
    int bad   = 0;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clka        (clka),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .txd         (txd),
        .busy        (busy),
        .tx_overflow (tx_overflow)
    );

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: a queue of waiting bytes and the position inside the frame on the line.
    logic [7:0] m_q[$];
    logic [7:0] m_acc[$];
    logic [9:0] m_frame;
    int         m_pos    = 0;
    bit         m_active = 1'b0;
    bit         m_ovf    = 1'b0;

    function automatic logic m_txd();
        return m_active ? m_frame[m_pos / CPB] : 1'b1;
    endfunction

    function automatic logic m_busy();
        return m_active || (m_q.size() != 0);
    endfunction

    function automatic logic m_ready();
        return m_q.size() < DEPTH;
    endfunction

    task automatic tick(input logic r, input logic s, input logic [7:0] d);
        int         sz;
        logic [7:0] hd;
        #1;
        rst      = r;
        tx_start = s;
        tx_data  = d;
        @(posedge clka);
        sz = m_q.size();
        if (r) begin
            m_q.delete();
            m_acc.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
        end else begin
            if (m_active) begin
                m_pos++;
                if (m_pos == FRAME) m_active = 1'b0;
            end
            if (!m_active && sz != 0) begin
                hd       = m_q.pop_front();
                m_frame  = {1'b1, hd, 1'b0};
                m_active = 1'b1;
                m_pos    = 0;
            end
            if (s) begin
                if (sz < DEPTH) begin
                    m_q.push_back(d);
                    m_acc.push_back(d);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(negedge clka);
    endtask

    // Serial receiver: samples mid-bit, independent of the model.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = '0;
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    int         rx_bad_stop = 0;

    always @(negedge clka) begin
        if (rst === 1'b1) begin
            rx_active = 1'b0;
            rx_cnt    = 0;
            rx_q.delete();
        end else if (!rx_active) begin
            if (txd === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2)
                rx_sh[rx_cnt / CPB - 1] = txd;
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                rx_active = 1'b0;
                if (txd === 1'b1) rx_q.push_back(rx_sh);
                else rx_bad_stop++;
            end
        end
    end

    task automatic test_reset();
        tick(1'b1, 1'b1, 8'hFF);
        tick(1'b1, 1'b1, 8'h3C);
        total++; if (txd !== 1'b1)         begin bad++; $display("FAIL reset_txd got=%b exp=1", txd); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (tx_ready !== 1'b1)    begin bad++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", tx_overflow); end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++; if (txd !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL reset_idle cyc=%0d got txd=%b busy=%b exp txd=1 busy=0", i, txd, busy);
            end
        end
    endtask

    task automatic test_single();
        logic [0:9] seq;
        seq = 10'b0101001011;
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++; if (txd !== seq[i / CPB]) begin
                bad++; $display("FAIL single_txd cyc=%0d got=%b exp=%b", i, txd, seq[i / CPB]);
            end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy cyc=%0d got=%b exp=1", i, busy); end
        end
        tick(1'b0, 1'b0, 8'h00);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        total++; if (txd !== 1'b1)  begin bad++; $display("FAIL single_txd_end got=%b exp=1", txd); end
        repeat (4) tick(1'b0, 1'b0, 8'h00);
        total++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            bad++; $display("FAIL single_rx got_n=%0d got0=%h exp=a5", rx_q.size(), rx_q.size() ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h00);
        tick(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 2 * FRAME - 1; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++; if (txd !== m_txd()) begin bad++; $display("FAIL b2b_txd cyc=%0d got=%b exp=%b", i, txd, m_txd()); end
            if (i == FRAME - 1) begin
                total++; if (txd !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b exp=0", txd); end
            end
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_last got=%b exp=1", busy); end
        tick(1'b0, 1'b0, 8'h00);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
        repeat (4) tick(1'b0, 1'b0, 8'h00);
        total++; if (rx_q.size() != 2 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF) begin
            bad++; $display("FAIL b2b_rx got_n=%0d exp_n=2 (00,ff)", rx_q.size());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d[6];
        tick(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 6; k++) d[k] = 8'(8'h30 + k * 17);
        for (int k = 0; k < 6; k++) begin
            if (k == 5) begin
                total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready got=%b exp=0", tx_ready); end
            end
            tick(1'b0, 1'b1, d[k]);
        end
        total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", tx_overflow); end
        for (int g = 0; g < 6 * FRAME && m_busy(); g++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++; if (txd !== m_txd() || tx_overflow !== 1'b1) begin
                bad++; $display("FAIL ovf_run cyc=%0d got txd=%b ovf=%b exp txd=%b ovf=1", g, txd, tx_overflow, m_txd());
            end
        end
        repeat (4) tick(1'b0, 1'b0, 8'h00);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovf_busy_end got=%b exp=0", busy); end
        total++; if (rx_q.size() != 5) begin bad++; $display("FAIL ovf_frames got=%0d exp=5", rx_q.size()); end
        for (int k = 0; k < 5 && k < rx_q.size(); k++) begin
            total++; if (rx_q[k] !== d[k]) begin bad++; $display("FAIL ovf_byte k=%0d got=%h exp=%h", k, rx_q[k], d[k]); end
        end
    endtask

    task automatic test_full_boundary();
        logic [7:0] d[6];
        tick(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 6; k++) d[k] = 8'($urandom);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, d[k]);
        for (int g = 0; g < 2 * FRAME && !(m_active && m_pos == FRAME - 1); g++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++; if (txd !== m_txd()) begin bad++; $display("FAIL fb_txd cyc=%0d got=%b exp=%b", g, txd, m_txd()); end
        end
        total++; if (!(m_active && m_pos == FRAME - 1)) begin bad++; $display("FAIL fb_reach got_pos=%0d exp_pos=%0d", m_pos, FRAME - 1); end
        tick(1'b0, 1'b1, d[4]);
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL fb_ready_3 got=%b exp=1", tx_ready); end
        total++; if (txd !== 1'b0)      begin bad++; $display("FAIL fb_start got=%b exp=0", txd); end
        tick(1'b0, 1'b1, d[5]);
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL fb_ready_4 got=%b exp=0", tx_ready); end
        for (int g = 0; g < 8 * FRAME && m_busy(); g++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++; if (txd !== m_txd() || tx_ready !== m_ready()) begin
                bad++; $display("FAIL fb_run cyc=%0d got txd=%b rdy=%b exp txd=%b rdy=%b", g, txd, tx_ready, m_txd(), m_ready());
            end
        end
        repeat (4) tick(1'b0, 1'b0, 8'h00);
        total++; if (rx_q.size() != 6) begin bad++; $display("FAIL fb_frames got=%0d exp=6", rx_q.size()); end
        for (int k = 0; k < 6 && k < rx_q.size(); k++) begin
            total++; if (rx_q[k] !== d[k]) begin bad++; $display("FAIL fb_byte k=%0d got=%h exp=%h", k, rx_q[k], d[k]); end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h5A);
        tick(1'b0, 1'b1, 8'h11);
        tick(1'b0, 1'b1, 8'h22);
        for (int g = 0; g < FRAME && !(m_active && m_pos == CPB * 4 + 1); g++) tick(1'b0, 1'b0, 8'h00);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL rmid_bit3 got=%b exp=1", txd); end
        tick(1'b1, 1'b0, 8'h00);
        total++; if (txd !== 1'b1)      begin bad++; $display("FAIL rmid_txd got=%b exp=1", txd); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", tx_ready); end
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++; if (txd !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL rmid_quiet cyc=%0d got txd=%b busy=%b exp txd=1 busy=0", i, txd, busy);
            end
        end
        total++; if (rx_q.size() != 0) begin bad++; $display("FAIL rmid_rx got=%0d exp=0", rx_q.size()); end
    endtask

    task automatic test_wrap();
        logic [7:0] d[10];
        logic [7:0] base;
        int         idx;
        base = 8'($urandom);
        for (int k = 0; k < 10; k++) d[k] = base + 8'(k * 37);
        tick(1'b1, 1'b0, 8'h00);
        idx = 0;
        for (int g = 0; g < 20 * FRAME && (idx < 10 || m_busy()); g++) begin
            if (idx < 10 && tx_ready === 1'b1) begin
                tick(1'b0, 1'b1, d[idx]);
                idx++;
            end else begin
                tick(1'b0, 1'b0, 8'h00);
            end
            total++; if (txd !== m_txd() || tx_ready !== m_ready()) begin
                bad++; $display("FAIL wrap_run cyc=%0d got txd=%b rdy=%b exp txd=%b rdy=%b", g, txd, tx_ready, m_txd(), m_ready());
            end
        end
        repeat (4) tick(1'b0, 1'b0, 8'h00);
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b exp=0", tx_overflow); end
        total++; if (rx_q.size() != 10) begin bad++; $display("FAIL wrap_frames got=%0d exp=10", rx_q.size()); end
        for (int k = 0; k < 10 && k < rx_q.size(); k++) begin
            total++; if (rx_q[k] !== d[k]) begin bad++; $display("FAIL wrap_byte k=%0d got=%h exp=%h", k, rx_q[k], d[k]); end
        end
    endtask

    task automatic test_random();
        logic       s;
        logic [7:0] d;
        int         rate;
        tick(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 800; i++) begin
            rate = (i < 400) ? 4 : 50;
            s = ($urandom_range(0, rate - 1) == 0);
            d = 8'($urandom);
            tick(1'b0, s, d);
            total++; if (txd !== m_txd() || busy !== m_busy() || tx_ready !== m_ready() || tx_overflow !== m_ovf) begin
                bad++;
                $display("FAIL rand_cyc cyc=%0d got txd=%b busy=%b rdy=%b ovf=%b exp txd=%b busy=%b rdy=%b ovf=%b",
                         i, txd, busy, tx_ready, tx_overflow, m_txd(), m_busy(), m_ready(), m_ovf);
            end
        end
        for (int g = 0; g < 8 * FRAME && m_busy(); g++) tick(1'b0, 1'b0, 8'h00);
        repeat (4) tick(1'b0, 1'b0, 8'h00);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_busy_end got=%b exp=0", busy); end
        total++; if (rx_q.size() != m_acc.size()) begin
            bad++; $display("FAIL rand_frames got=%0d exp=%0d", rx_q.size(), m_acc.size());
        end
        for (int k = 0; k < m_acc.size() && k < rx_q.size(); k++) begin
            total++; if (rx_q[k] !== m_acc[k]) begin bad++; $display("FAIL rand_byte k=%0d got=%h exp=%h", k, rx_q[k], m_acc[k]); end
        end
        total++; if (rx_bad_stop != 0) begin bad++; $display("FAIL rx_stop_bits got=%0d exp=0", rx_bad_stop); end
    endtask

    initial begin
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_boundary();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
